// File: rtl/icebus_status_decoder.sv
// icebus_status_decoder: motor-link frame parser (sync hunt, CRC-16/CCITT-FALSE check, field decode, link counters).
// Optional inter-byte timeout enabled by defining ICEBUS_DECODER_TIMEOUT_EN.
module icebus_status_decoder #(
  parameter int          NUMBER_OF_MOTORS = 6,
  parameter logic [31:0] SYNC_WORD        = 32'hA55AA55A,
  parameter int          TIMEOUT_CYCLES   = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_break,
  output logic        upd_valid,
  output logic [7:0]  upd_motor,
  output logic [31:0] upd_enc0_pos,
  output logic [31:0] upd_enc1_pos,
  output logic [31:0] upd_enc0_vel,
  output logic [31:0] upd_enc1_vel,
  output logic [31:0] upd_cur1,
  output logic [31:0] upd_cur2,
  output logic [31:0] upd_cur3,
  output logic [31:0] upd_error_code,
  output logic [15:0] upd_crc,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames
);
  typedef enum logic [2:0] {HUNT, PAYLOAD, CRC_HI, CRC_LO, CHECK} state_t;
  localparam logic [7:0] MAX_ID = 8'(NUMBER_OF_MOTORS);
  state_t state, state_n;
  logic [31:0] hist, hist_n;
  logic [215:0] shadow;
  logic [15:0] crc, crc_rx;
  logic [4:0] cnt;
  logic in_frame, abort, timeout, bad_id, bad_crc, ev_good, ev_err;
  logic [1:0] ev_code;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction
`ifdef ICEBUS_DECODER_TIMEOUT_EN
  logic [31:0] gap;
  assign timeout = in_frame && !rx_valid && gap == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) gap <= '0;
    else gap <= (!in_frame || rx_valid) ? '0 : gap + 32'd1;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= HUNT;
    else state <= state_n;
  always_comb begin
    hist_n   = {hist[23:0], rx_data};
    in_frame = state == PAYLOAD || state == CRC_HI || state == CRC_LO;
    abort    = in_frame && (rx_break || timeout);
    bad_id   = shadow[215:208] >= MAX_ID;
    bad_crc  = crc != crc_rx;
    ev_good  = state == CHECK && !bad_id && !bad_crc;
    ev_err   = abort || (state == CHECK && (bad_id || bad_crc));
    ev_code  = abort ? 2'd3 : bad_id ? 2'd2 : 2'd1;
    state_n  = state;
    case (state)
      HUNT:    state_n = (rx_valid && !rx_break && hist_n == SYNC_WORD) ? PAYLOAD : HUNT;
      PAYLOAD: state_n = (rx_valid && cnt == 5'd26) ? CRC_HI : PAYLOAD;
      CRC_HI:  state_n = rx_valid ? CRC_LO : CRC_HI;
      CRC_LO:  state_n = rx_valid ? CHECK : CRC_LO;
      default: state_n = HUNT;
    endcase
    if (abort) state_n = HUNT;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hist           <= '0;
      shadow         <= '0;
      crc            <= 16'hFFFF;
      crc_rx         <= '0;
      cnt            <= '0;
      upd_valid      <= 1'b0;
      upd_motor      <= '0;
      upd_enc0_pos   <= '0;
      upd_enc1_pos   <= '0;
      upd_enc0_vel   <= '0;
      upd_enc1_vel   <= '0;
      upd_cur1       <= '0;
      upd_cur2       <= '0;
      upd_cur3       <= '0;
      upd_error_code <= '0;
      upd_crc        <= '0;
      err_valid      <= 1'b0;
      err_code       <= '0;
      good_frames    <= '0;
      bad_frames     <= '0;
    end else begin
      upd_valid <= ev_good;
      err_valid <= ev_err;
      // history is only meaningful while hunting; it stays clear for the whole frame
      if (state == HUNT)
        hist <= (rx_break || (rx_valid && hist_n == SYNC_WORD)) ? '0 : rx_valid ? hist_n : hist;
      if (state == HUNT) begin
        crc <= 16'hFFFF;
        cnt <= '0;
      end else if (state == PAYLOAD && rx_valid && !abort) begin
        shadow <= {shadow[207:0], rx_data};
        crc    <= crc_step(crc, rx_data);
        cnt    <= cnt + 5'd1;
      end
      if ((state == CRC_HI || state == CRC_LO) && rx_valid && !abort) crc_rx <= {crc_rx[7:0], rx_data};
      if (ev_err) err_code <= ev_code;
      if (ev_good) begin
        upd_motor      <= shadow[215:208];
        upd_enc0_pos   <= shadow[207:176];
        upd_enc1_pos   <= shadow[175:144];
        upd_enc0_vel   <= shadow[143:112];
        upd_enc1_vel   <= shadow[111:80];
        upd_cur1       <= {{16{shadow[79]}}, shadow[79:64]};
        upd_cur2       <= {{16{shadow[63]}}, shadow[63:48]};
        upd_cur3       <= {{16{shadow[47]}}, shadow[47:32]};
        upd_error_code <= shadow[31:0];
        upd_crc        <= crc_rx;
      end
      good_frames <= good_frames + {15'd0, ev_good && good_frames != 16'hFFFF};
      bad_frames  <= bad_frames + {15'd0, ev_err && bad_frames != 16'hFFFF};
    end
endmodule

// File: tb/tb_icebus_status_decoder.sv
// tb_icebus_status_decoder: directed and randomized frames checked against a field-level reference model.
module tb_icebus_status_decoder;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, reset = 1, rx_valid = 0, rx_break = 0;
  logic [7:0] rx_data = 0;
  logic upd_valid, err_valid;
  logic [7:0] upd_motor;
  logic [31:0] upd_enc0_pos, upd_enc1_pos, upd_enc0_vel, upd_enc1_vel;
  logic [31:0] upd_cur1, upd_cur2, upd_cur3, upd_error_code;
  logic [15:0] upd_crc, good_frames, bad_frames;
  logic [1:0] err_code;
  int checks = 0, failures = 0;
  logic [7:0] e_motor = 0;
  logic [31:0] e_p0 = 0, e_p1 = 0, e_v0 = 0, e_v1 = 0, e_c1 = 0, e_c2 = 0, e_c3 = 0, e_ec = 0;
  logic [15:0] e_crc = 0, e_good = 0, e_bad = 0;

  always #5 clk = ~clk;

  icebus_status_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
    .upd_valid(upd_valid), .upd_motor(upd_motor),
    .upd_enc0_pos(upd_enc0_pos), .upd_enc1_pos(upd_enc1_pos),
    .upd_enc0_vel(upd_enc0_vel), .upd_enc1_vel(upd_enc1_vel),
    .upd_cur1(upd_cur1), .upd_cur2(upd_cur2), .upd_cur3(upd_cur3),
    .upd_error_code(upd_error_code), .upd_crc(upd_crc),
    .err_valid(err_valid), .err_code(err_code),
    .good_frames(good_frames), .bad_frames(bad_frames)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bit-serial CRC-16/CCITT-FALSE over a whole message
  function automatic logic [15:0] crc_ref(input bq_t q);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    foreach (q[k])
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ q[k][b];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1;
    rx_data = b;
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_sync(input int gap);
    logic [31:0] s;
    s = 32'hA55AA55A;
    for (int k = 3; k >= 0; k--) send_byte(s[8*k+7 -: 8], gap);
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".motor"}, upd_motor, e_motor);
    check({tag, ".p0"}, upd_enc0_pos, e_p0);
    check({tag, ".p1"}, upd_enc1_pos, e_p1);
    check({tag, ".v0"}, upd_enc0_vel, e_v0);
    check({tag, ".v1"}, upd_enc1_vel, e_v1);
    check({tag, ".c1"}, upd_cur1, e_c1);
    check({tag, ".c2"}, upd_cur2, e_c2);
    check({tag, ".c3"}, upd_cur3, e_c3);
    check({tag, ".ec"}, upd_error_code, e_ec);
    check({tag, ".crc"}, upd_crc, e_crc);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] id, input logic [31:0] p0, p1, v0, v1,
                           input logic [15:0] c1, c2, c3, input logic [31:0] ec,
                           input logic [15:0] flip, input int gap);
    bq_t q;
    logic [215:0] flat;
    logic [15:0] crc;
    logic good;
    flat = {id, p0, p1, v0, v1, c1, c2, c3, ec};
    for (int k = 0; k < 27; k++) q.push_back(flat[215-8*k -: 8]);
    crc = crc_ref(q) ^ flip;
    send_sync(gap);
    foreach (q[k]) send_byte(q[k], gap);
    send_byte(crc[15:8], gap);
    send_byte(crc[7:0], gap);
    check({tag, ".early"}, {upd_valid, err_valid}, 2'b00);
    @(negedge clk);
    good = id < 8'd6 && flip == 16'h0000;
    check({tag, ".upd_valid"}, upd_valid, good);
    check({tag, ".err_valid"}, err_valid, !good);
    if (!good) check({tag, ".err_code"}, err_code, id >= 8'd6 ? 2'd2 : 2'd1);
    if (good) begin
      e_motor = id; e_p0 = p0; e_p1 = p1; e_v0 = v0; e_v1 = v1;
      e_c1 = 32'(signed'(c1)); e_c2 = 32'(signed'(c2)); e_c3 = 32'(signed'(c3));
      e_ec = ec; e_crc = crc;
      e_good = sat_inc(e_good);
    end else e_bad = sat_inc(e_bad);
    check_fields(tag);
    @(negedge clk);
    check({tag, ".drop"}, {upd_valid, err_valid}, 2'b00);
    check({tag, ".good_frames"}, good_frames, e_good);
    check({tag, ".bad_frames"}, bad_frames, e_bad);
  endtask

  task automatic std_frame(input string tag, input logic [7:0] id, input logic [15:0] flip, input int gap);
    run_frame(tag, id, 32'h00001234, 32'hFFFFFFFE, 32'h00000010, 32'h00000020,
              16'hFF38, 16'h0064, 16'h0000, 32'h0, flip, gap);
  endtask

  initial begin
    bq_t ascii;
    ascii = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("crc_unit", crc_ref(ascii), 16'h29B1);
    repeat (3) @(negedge clk);
    check("rst.pulses", {upd_valid, err_valid, err_code}, 4'b0);
    check("rst.counters", {good_frames, bad_frames}, 32'h0);
    check_fields("rst");
    reset = 0;
    @(negedge clk);
    std_frame("good_b2b", 8'd2, 16'h0000, 0);
    check("good.enc1_neg2", upd_enc1_pos, 32'hFFFFFFFE);
    check("good.cur1_sext", upd_cur1, 32'hFFFFFF38);
    std_frame("good_gap10", 8'd2, 16'h0000, 10);
    std_frame("bad_crc", 8'd2, 16'h0001, 0);
    std_frame("bad_id6", 8'd6, 16'h0000, 1);
    std_frame("bad_id_crc", 8'd9, 16'h0100, 0);
    std_frame("good_id5", 8'd5, 16'h0000, 0);
    send_byte(8'hA5, 0);
    std_frame("overlap_sync", 8'd1, 16'h0000, 0);
    send_sync(0);
    for (int k = 0; k < 10; k++) send_byte(8'($urandom_range(0, 255)), 0);
    rx_break = 1; rx_valid = 1; rx_data = 8'h5A;
    @(negedge clk);
    rx_break = 0; rx_valid = 0;
    check("break.err_valid", err_valid, 1'b1);
    check("break.err_code", err_code, 2'd3);
    check("break.upd_valid", upd_valid, 1'b0);
    e_bad = sat_inc(e_bad);
    check_fields("break");
    @(negedge clk);
    check("break.bad_frames", bad_frames, e_bad);
    std_frame("after_break", 8'd3, 16'h0000, 0);
    send_byte(8'hA5, 0); send_byte(8'h5A, 0); send_byte(8'hA5, 0);
    rx_break = 1;
    @(negedge clk);
    rx_break = 0;
    check("hunt_break.quiet", {upd_valid, err_valid}, 2'b00);
    send_byte(8'h5A, 0);
    std_frame("hunt_break_frame", 8'd4, 16'h0000, 0);
`ifdef ICEBUS_DECODER_TIMEOUT_EN
    begin
      int waited;
      send_sync(0);
      for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)), 0);
      waited = 0;
      while (!err_valid && waited < 150) begin
        @(negedge clk);
        waited++;
      end
      check("timeout.err_valid", err_valid, 1'b1);
      check("timeout.err_code", err_code, 2'd3);
      e_bad = sat_inc(e_bad);
      @(negedge clk);
      check("timeout.bad_frames", bad_frames, e_bad);
    end
`endif
    for (int n = 0; n < 24; n++) begin
      logic [15:0] flip;
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 63)), $urandom_range(0, 2));
      flip = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      run_frame($sformatf("rand%0d", n), 8'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                $urandom, 16'($urandom), 16'($urandom), 16'($urandom), $urandom, flip,
                $urandom_range(0, 3));
    end
    send_sync(0);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)), 0);
    reset = 1;
    @(negedge clk);
    check("midrst.pulses", {upd_valid, err_valid, err_code}, 4'b0);
    check("midrst.counters", {good_frames, bad_frames}, 32'h0);
    e_motor = 0; e_p0 = 0; e_p1 = 0; e_v0 = 0; e_v1 = 0;
    e_c1 = 0; e_c2 = 0; e_c3 = 0; e_ec = 0; e_crc = 0; e_good = 0; e_bad = 0;
    check_fields("midrst");
    reset = 0;
    @(negedge clk);
    std_frame("after_rst", 8'd0, 16'h0000, 0);
    force dut.bad_frames = 16'hFFFE;
    #1;
    release dut.bad_frames;
    e_bad = 16'hFFFE;
    std_frame("sat1", 8'd2, 16'h8000, 0);
    std_frame("sat2", 8'd7, 16'h0000, 0);
    check("sat.hold", bad_frames, 16'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
